cgra_rf_seq: RTL and testbench
==============================

# cgra_rf_seq

Thread-batch operand sequencer and writeback collector for the CGRA subsystem. It sits on the register-file side of the per-port latency pipes. Each cycle it streams one thread's operand words onto `rf_rdata`. After a programmable round-trip latency it captures the CGRA results from `rf_wdata` into a per-thread result store. A host port loads operands before a batch and reads results after it.

## Interface
Parameters:
- `NUM_PORTS`, 4: operand/result words per thread
- `WIDTH`, 32: word width
- `NUM_THREADS`, 16: threads per batch; power of 2
- `MAX_WB_LAT`, 64: maximum round-trip latency; power of 2

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `clr` in 1: synchronous abort; returns block to IDLE
- `start` in 1: batch start pulse; accepted only in IDLE
- `thread_count` in $clog2(NUM_THREADS)+1: number of threads in the batch, 0..NUM_THREADS
- `wb_latency` in $clog2(MAX_WB_LAT)+1: round-trip latency, 1..MAX_WB_LAT
- `busy` out 1: high in ISSUE and DRAIN
- `done` out 1: one-cycle pulse when a batch completes
- `host_we` in 1: host write to operand store
- `host_addr` in $clog2(NUM_THREADS*NUM_PORTS): address = {thread, port}
- `host_wdata` in WIDTH: host write data
- `host_rdata` out WIDTH: result store word at the previous cycle's `host_addr`
- `rf_rvalid` out 1: `rf_rdata` carries a thread's operands this cycle
- `rf_rdata` out NUM_PORTS*WIDTH: operand words; port i at [i*WIDTH +: WIDTH]
- `rf_wdata` in NUM_PORTS*WIDTH: result words, same packing

## Operation
The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `start`, latch `thread_count` and `wb_latency` and clear `issue_ptr` and `retire_cnt`.
  - If the latched count is 0, go to DONE. Otherwise go to ISSUE.
- **ISSUE**
  - Each cycle, read `op_mem[issue_ptr]` into the `rf_rdata` register, set `rf_rvalid`, and push {valid=1, tid=issue_ptr} into the writeback delay line.
  - `issue_ptr` increments each cycle. After count-1 is issued, go to DRAIN.
- **DRAIN**
  - No issue; `rf_rvalid` is 0.
  - When `retire_cnt` reaches the latched count, go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **Writeback delay line**
  - Shift register of {valid, tid}, MAX_WB_LAT entries deep.
  - Retire tap is at index latched `wb_latency`-1.
  - When the tap entry is valid: write `rf_wdata` to `res_mem[tid]` (all ports) and increment `retire_cnt`.
  - Retirement also happens in ISSUE, overlapping with issue.
- **Host port**
  - `host_we` writes are applied only in IDLE or DONE and ignored while `busy`.
  - `host_rdata` is always served from `res_mem` (registered read).
- **Boundary behaviour**
  - `start` while not IDLE: ignored.
  - `thread_count` > NUM_THREADS: clamp to NUM_THREADS.
  - `wb_latency` of 0: treat as 1.
  - `clr` (priority over everything except `rst`): state→IDLE, delay line valids cleared, `rf_rvalid`=0, `done`=0. `op_mem` and `res_mem` keep their contents.
  - `rst`: same as `clr`, plus all counters and the `rf_rdata` register go to 0. Memories are not reset.

## Timing
- Reset values: `busy`=0, `done`=0, `rf_rvalid`=0, `rf_rdata`=0, `host_rdata`=0.
- `start` sampled at cycle s → thread 0 on `rf_rdata` at s+1, thread k at s+1+k.
- A thread presented on `rf_rdata` at cycle c has its result sampled from `rf_wdata` at the rising edge ending cycle c+`wb_latency`.
- N≥1 threads: `done` at cycle s+N+`wb_latency`+1. `busy` is high from s+1 through s+N+`wb_latency`.
- N=0: `done` at s+1.
- `host_rdata` lags `host_addr` by one cycle. A host read in the same cycle as a retirement to the same word returns the old value.

## Structure
- Shared package `cgra_rf_pkg` holds:
  - the FSM state enum
  - the `{valid, tid}` writeback-tag struct
  - a localparam helper for the address width
- Natural sub-module `wb_tag_delay`: a variable-tap shift register of tags with a clear input.
- Memories are plain arrays inferred as flops or distributed RAM.

## Test plan
- Load `op_mem` with thread t, port p = 0x100*t+p. Loop back `rf_rdata` to `rf_wdata` through a 5-cycle model, with `wb_latency`=5 and `thread_count`=16. Expect `res_mem` = `op_mem` and `done` at s+22.
- `thread_count`=0 → `done` at s+1, no `rf_rvalid`, `res_mem` unchanged.
- `wb_latency`=1 and MAX_WB_LAT with count=3 → `done` at s+5 and s+68 respectively. Results are written to the correct tid.
- Pulse `clr` mid-ISSUE (thread 4 of 10) → IDLE next cycle, no further retirements, no `done`. A new `start` then completes normally.
- Assert `rst` mid-DRAIN → all outputs 0 asynchronously. `start` pulses and `host_we` writes during `busy` are ignored.
- `thread_count`=20 (clamped to 16) → exactly 16 `rf_rvalid` cycles.

Source files
------------

// File: rtl/cgra_rf_pkg.sv
// cgra_rf_pkg: shared FSM states, writeback tag and address-width helper for cgra_rf_seq
package cgra_rf_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int TID_W = 8;
  typedef struct packed {
    logic valid;
    logic [TID_W-1:0] tid;
  } wb_tag_t;
  function automatic int addr_w(input int threads, input int ports);
    return $clog2(threads * ports);
  endfunction
endpackage

// File: rtl/cgra_rf_seq_wb_tag_delay.sv
// wb_tag_delay: shift register of writeback tags with a programmable retire tap
module wb_tag_delay
  import cgra_rf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  wb_tag_t          tag,
  input  logic [LAT_W-1:0] lat,
  output wb_tag_t          tap
);
  localparam int IW = $clog2(DEPTH);
  wb_tag_t line [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      line[0] <= clr ? '0 : tag;
      for (int i = 1; i < DEPTH; i++) line[i] <= clr ? '0 : line[i-1];
    end
  // lat is already clamped to 1..DEPTH by the caller
  assign tap = line[IW'(lat - 1'b1)];
endmodule

// File: rtl/cgra_rf_seq.sv
// cgra_rf_seq: streams per-thread operands to the CGRA and collects delayed results
module cgra_rf_seq
  import cgra_rf_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int WIDTH       = 32,
  parameter int NUM_THREADS = 16,
  parameter int MAX_WB_LAT  = 64
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         clr,
  input  logic                                         start,
  input  logic [$clog2(NUM_THREADS):0]                 thread_count,
  input  logic [$clog2(MAX_WB_LAT):0]                  wb_latency,
  output logic                                         busy,
  output logic                                         done,
  input  logic                                         host_we,
  input  logic [addr_w(NUM_THREADS, NUM_PORTS)-1:0]    host_addr,
  input  logic [WIDTH-1:0]                             host_wdata,
  output logic [WIDTH-1:0]                             host_rdata,
  output logic                                         rf_rvalid,
  output logic [NUM_PORTS*WIDTH-1:0]                   rf_rdata,
  input  logic [NUM_PORTS*WIDTH-1:0]                   rf_wdata
);
  localparam int CW = $clog2(NUM_THREADS) + 1;
  localparam int LW = $clog2(MAX_WB_LAT) + 1;
  localparam int AW = addr_w(NUM_THREADS, NUM_PORTS);
  state_t                     state;
  logic [CW-1:0]              cnt, cnt_in, issue_ptr, retire_cnt;
  logic [LW-1:0]              lat, lat_in;
  logic [TID_W-1:0]           tid_q;
  logic [WIDTH-1:0]           op_mem  [NUM_THREADS*NUM_PORTS];
  logic [WIDTH-1:0]           res_mem [NUM_THREADS*NUM_PORTS];
  logic [NUM_PORTS*WIDTH-1:0] op_word;
  wb_tag_t                    tag_in, tap;
  logic                       retire;
  assign cnt_in = thread_count > CW'(NUM_THREADS) ? CW'(NUM_THREADS) : thread_count;
  assign lat_in = wb_latency == '0 ? LW'(1) :
                  wb_latency > LW'(MAX_WB_LAT) ? LW'(MAX_WB_LAT) : wb_latency;
  assign retire = tap.valid && !clr;
  // the tag follows the registered operand word, so the tap lines up with the round trip
  assign tag_in = '{valid: rf_rvalid, tid: tid_q};
  always_comb begin
    op_word = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      op_word[p*WIDTH +: WIDTH] = op_mem[AW'(int'(issue_ptr) * NUM_PORTS + p)];
  end
  wb_tag_delay #(.DEPTH(MAX_WB_LAT), .LAT_W(LW)) u_dly (
    .clk(clk), .rst(rst), .clr(clr), .tag(tag_in), .lat(lat), .tap(tap)
  );
  always_ff @(posedge clk) begin
    if (host_we && !clr && (state == IDLE || state == DONE)) op_mem[host_addr] <= host_wdata;
    if (retire)
      for (int p = 0; p < NUM_PORTS; p++)
        res_mem[AW'(int'(tap.tid) * NUM_PORTS + p)] <= rf_wdata[p*WIDTH +: WIDTH];
  end
  // issue_ptr rests at 0 in IDLE so the start edge already presents thread 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rf_rvalid  <= 1'b0;
      rf_rdata   <= '0;
      tid_q      <= '0;
      issue_ptr  <= '0;
      retire_cnt <= '0;
      cnt        <= '0;
      lat        <= LW'(1);
      host_rdata <= '0;
    end else begin
      host_rdata <= res_mem[host_addr];
      if (clr) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        rf_rvalid <= 1'b0;
        issue_ptr <= '0;
      end else begin
        done      <= 1'b0;
        rf_rvalid <= 1'b0;
        if (retire) retire_cnt <= retire_cnt + 1'b1;
        case (state)
          IDLE: if (start) begin
            cnt        <= cnt_in;
            lat        <= lat_in;
            retire_cnt <= '0;
            if (cnt_in == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              busy      <= 1'b1;
              rf_rvalid <= 1'b1;
              rf_rdata  <= op_word;
              tid_q     <= '0;
              issue_ptr <= CW'(1);
            end
          end
          ISSUE: if (issue_ptr == cnt) state <= DRAIN;
          else begin
            rf_rvalid <= 1'b1;
            rf_rdata  <= op_word;
            tid_q     <= TID_W'(issue_ptr);
            issue_ptr <= issue_ptr + 1'b1;
          end
          DRAIN: if (retire && retire_cnt + 1'b1 == cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            issue_ptr <= '0;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_cgra_rf_seq.sv
// tb_cgra_rf_seq: directed self-checking bench for cgra_rf_seq
module tb_cgra_rf_seq;
  localparam int ML = 64;
  logic         clk = 0, rst = 1, clr = 0, start = 0, host_we = 0;
  logic [4:0]   thread_count = '0;
  logic [6:0]   wb_latency = 7'd1;
  logic         busy, done, rf_rvalid;
  logic [5:0]   host_addr = '0;
  logic [31:0]  host_wdata = '0, host_rdata;
  logic [127:0] rf_rdata, rf_wdata;
  logic [127:0] pipe [ML];
  int           lb_lat = 5;
  int           checks = 0, fails = 0;
  logic [31:0]  mop [64], mres [64];
  bit           known [64];
  cgra_rf_seq dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .thread_count(thread_count),
    .wb_latency(wb_latency), .busy(busy), .done(done), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .rf_rvalid(rf_rvalid), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata)
  );
  always #5 clk = ~clk;
  // loopback: the CGRA result equals the operand word, lb_lat cycles later
  always @(posedge clk) begin
    pipe[0] <= rf_rdata;
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign rf_wdata = pipe[6'(lb_lat - 1)];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] opw(input int t);
    return {mop[t*4+3], mop[t*4+2], mop[t*4+1], mop[t*4]};
  endfunction
  task automatic wr_op(input int a, input logic [31:0] d);
    host_addr = 6'(a); host_wdata = d; host_we = 1;
    @(negedge clk);
    host_we = 0;
    mop[a] = d;
  endtask
  task automatic check_res();
    for (int a = 0; a < 64; a++)
      if (known[a]) begin
        host_addr = 6'(a);
        @(negedge clk);
        chk($sformatf("res%0d", a), 128'(host_rdata), 128'(mres[a]));
      end
  endtask
  task automatic retire_model(input int n);
    for (int a = 0; a < n * 4; a++) begin mres[a] = mop[a]; known[a] = 1; end
  endtask
  task automatic run_batch(input int n, input int lat, input int lb, input int poke,
                           output int done_at, output int rv, output logic [127:0] second);
    lb_lat = lb; thread_count = 5'(n); wb_latency = 7'(lat); start = 1;
    done_at = -1; rv = 0; second = '0;
    @(negedge clk);
    for (int k = 1; k <= 150; k++) begin
      start = 0; host_we = 0;
      if (rf_rvalid) rv++;
      if (k == 2) second = rf_rdata;
      if (done) begin done_at = k; break; end
      if (k == poke) begin
        start = 1; thread_count = 5'd16; host_we = 1; host_addr = '0; host_wdata = 32'hDEAD;
      end
      @(negedge clk);
    end
    start = 0; host_we = 0;
    @(negedge clk);
    chk("done_pulse", 128'({done, busy}), 128'(0));
  endtask
  initial begin
    int d, rv, quiet;
    logic [127:0] sec;
    for (int a = 0; a < 64; a++) known[a] = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_ctl", 128'({busy, done, rf_rvalid}), 128'(0));
    chk("rst_rdata", rf_rdata, 128'(0));
    chk("rst_hrdata", 128'(host_rdata), 128'(0));
    rst = 0;
    @(negedge clk);
    for (int t = 0; t < 16; t++) for (int p = 0; p < 4; p++) wr_op(t*4+p, 32'(32'h100*t+p));
    run_batch(16, 5, 5, 0, d, rv, sec);
    chk("full_done", 128'(d), 128'(22));
    chk("full_rv", 128'(rv), 128'(16));
    chk("full_thread1", sec, 128'h00000103_00000102_00000101_00000100);
    retire_model(16); check_res();
    run_batch(0, 5, 5, 0, d, rv, sec);
    chk("zero_done", 128'(d), 128'(1));
    chk("zero_rv", 128'(rv), 128'(0));
    check_res();
    for (int a = 0; a < 12; a++) wr_op(a, 32'(32'hA000 + a));
    run_batch(3, 1, 1, 0, d, rv, sec);
    chk("lat1_done", 128'(d), 128'(5));
    chk("lat1_rv", 128'(rv), 128'(3));
    retire_model(3); check_res();
    for (int a = 0; a < 12; a++) wr_op(a, 32'(32'hB000 + a));
    run_batch(3, 64, 64, 0, d, rv, sec);
    chk("lat64_done", 128'(d), 128'(68));
    retire_model(3); check_res();
    for (int a = 0; a < 4; a++) wr_op(a, 32'(32'hC000 + a));
    run_batch(1, 0, 1, 0, d, rv, sec);
    chk("lat0_done", 128'(d), 128'(3));
    retire_model(1); check_res();
    run_batch(3, 2, 2, 2, d, rv, sec);
    chk("busy_start_done", 128'(d), 128'(6));
    chk("busy_start_rv", 128'(rv), 128'(3));
    retire_model(3); check_res();
    for (int a = 0; a < 40; a++) wr_op(a, 32'(32'hD000 + a));
    lb_lat = 5; thread_count = 5'd10; wb_latency = 7'd5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("clr_thread4", rf_rdata, opw(4));
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clr_idle", 128'({busy, rf_rvalid}), 128'(0));
    quiet = 0;
    repeat (20) begin @(negedge clk); if (done || busy) quiet++; end
    chk("clr_quiet", 128'(quiet), 128'(0));
    check_res();
    run_batch(10, 5, 5, 0, d, rv, sec);
    chk("after_clr_done", 128'(d), 128'(16));
    retire_model(10); check_res();
    thread_count = 5'd4; wb_latency = 7'd10; lb_lat = 10; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    chk("drain_state", 128'({busy, rf_rvalid}), 128'(2));
    #2 rst = 1;
    #1 chk("arst_ctl", 128'({busy, done, rf_rvalid}), 128'(0));
    chk("arst_data", {rf_rdata, host_rdata} == '0 ? 128'(0) : 128'(1), 128'(0));
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_res();
    run_batch(20, 5, 5, 0, d, rv, sec);
    chk("clamp_rv", 128'(rv), 128'(16));
    chk("clamp_done", 128'(d), 128'(22));
    retire_model(16); check_res();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
